// File: rtl/scan_config_ctrl.sv
// scan_config_ctrl: programs a serial connection scan chain from a stream of
// configuration words, LSB first, and folds the bits returned from the chain
// tail into a running parity.
module scan_config_ctrl #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  scan_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  chain_len,
    input  logic [WORD_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  conn_scan_en,
    output logic                  conn_scan_in,
    input  logic                  conn_scan_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  chk_parity
);

    localparam int unsigned IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [WORD_WIDTH-1:0]   shreg_q, shreg_d;
    logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
    logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
    logic                    parity_q, parity_d;
    logic                    err_d;

    logic cfg_ready_q;
    logic scan_en_q;
    logic scan_in_q;
    logic busy_q;
    logic done_q;
    logic err_q;

    // Next-state and datapath update for the shift sequencer.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        remaining_d = remaining_q;
        bit_idx_d   = bit_idx_q;
        parity_d    = parity_q;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (chain_len != '0) begin
                        remaining_d = chain_len;
                        parity_d    = 1'b0;
                        state_d     = FETCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (cfg_valid) begin
                    shreg_d   = cfg_data;
                    bit_idx_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d     = shreg_q >> 1;
                remaining_d = remaining_q - LEN_WIDTH'(1);
                bit_idx_d   = bit_idx_q + IDX_W'(1);
                parity_d    = parity_q ^ conn_scan_out;
                // Chain end wins over word end; leftover word bits are dropped.
                if (remaining_q == LEN_WIDTH'(1)) begin
                    state_d = DONE;
                end else if (bit_idx_q == LAST_IDX) begin
                    state_d = FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; outputs are decoded from the next state
    // so they line up with the registered state.
    always_ff @(posedge scan_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            remaining_q <= '0;
            bit_idx_q   <= '0;
            parity_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
            scan_en_q   <= 1'b0;
            scan_in_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            remaining_q <= remaining_d;
            bit_idx_q   <= bit_idx_d;
            parity_q    <= parity_d;
            cfg_ready_q <= (state_d == FETCH);
            scan_en_q   <= (state_d == SHIFT);
            scan_in_q   <= (state_d == SHIFT) & shreg_d[0];
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
            err_q       <= err_d;
        end
    end

    assign cfg_ready    = cfg_ready_q;
    assign conn_scan_en = scan_en_q;
    assign conn_scan_in = scan_in_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign chk_parity   = parity_q;

endmodule
